// File: rtl/nbody_pkg.sv
`default_nettype none
// ============================================================================
// Module : nbody_pkg
// Brief  : Shared record layouts, constants and FSM encoding for the
//          n-body integrator.
// Rev    : 1.0 - initial release
// ============================================================================
package nbody_pkg;

    localparam int c_rec_w              = 80;
    localparam int c_force_base_default = 400;

    // Body record as stored in BRAM, MSB-first: {x, y, vx, vy, mass}
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] vx;
        logic signed [15:0] vy;
        logic        [15:0] mass;
    } body_t;

    typedef struct packed {
        logic        [15:0] pad;
        logic signed [31:0] fx;
        logic signed [31:0] fy;
    } force_rec_t;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_BODY   = 4'd1,
        CAP_BODY  = 4'd2,
        RD_FORCE  = 4'd3,
        CAP_FORCE = 4'd4,
        UPDATE    = 4'd5,
        WRITE     = 4'd6,
        NEXT      = 4'd7,
        DONE      = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nbody_integrator_body_update.sv
`default_nettype none
// ============================================================================
// Module : body_update
// Brief  : Combinational fixed-point Euler step for one body. fit16 clamps
//          when NBODY_INTEG_SATURATE_EN is defined, otherwise wraps.
// Rev    : 1.0 - initial release
// ============================================================================
module body_update
    import nbody_pkg::*;
#(
    parameter int DT_SHIFT  = 7,
    parameter int POS_SHIFT = 2
) (
    input  body_t              i_body,
    input  logic signed [31:0] i_fx,
    input  logic signed [31:0] i_fy,
    output body_t              o_body
);

    function automatic logic signed [15:0] fit16(input logic signed [33:0] v);
`ifdef NBODY_INTEG_SATURATE_EN
        if (v > 34'sd32767) begin
            return 16'sh7fff;
        end
        if (v < -34'sd32768) begin
            return 16'sh8000;
        end
        return v[15:0];
`else
        return 16'(v);
`endif
    endfunction

    // Returns {p_new, v_new}; velocity is updated first, position uses the new velocity.
    function automatic logic [31:0] step_axis(
        input logic signed [15:0] p,
        input logic signed [15:0] v,
        input logic signed [31:0] f
    );
        logic signed [31:0] dv;
        logic signed [33:0] v_ext;
        logic signed [15:0] v_new;
        logic signed [15:0] dp;
        logic signed [17:0] p_ext;
        logic signed [15:0] p_new;
        dv    = f >>> DT_SHIFT;
        v_ext = {{18{v[15]}}, v} + {{2{dv[31]}}, dv};
        v_new = fit16(v_ext);
        dp    = v_new >>> POS_SHIFT;
        p_ext = {{2{p[15]}}, p} + {{2{dp[15]}}, dp};
        p_new = fit16({{16{p_ext[17]}}, p_ext});
        return {p_new, v_new};
    endfunction

    logic [31:0] w_x_step;
    logic [31:0] w_y_step;

    assign w_x_step = step_axis(i_body.x, i_body.vx, i_fx);
    assign w_y_step = step_axis(i_body.y, i_body.vy, i_fy);

    always_comb begin
        o_body      = i_body;
        o_body.x    = w_x_step[31:16];
        o_body.vx   = w_x_step[15:0];
        o_body.y    = w_y_step[31:16];
        o_body.vy   = w_y_step[15:0];
        o_body.mass = i_body.mass;
    end

endmodule
`default_nettype wire

// File: rtl/nbody_integrator.sv
`default_nettype none
// ============================================================================
// Module : nbody_integrator
// Brief  : Walks bodies 0..N-1 over the shared BRAM port, applies an Euler
//          step from the force records and writes each body back in place.
//          Optional NBODY_INTEG_SATURATE_EN selects clamping arithmetic.
// Rev    : 1.0 - initial release
// ============================================================================
module nbody_integrator
    import nbody_pkg::*;
#(
    parameter int N          = 16,
    parameter int FORCE_BASE = c_force_base_default,
    parameter int DT_SHIFT   = 7,
    parameter int POS_SHIFT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               done,
    output logic [15:0]        mem_addr,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [c_rec_w-1:0] mem_wdata,
    input  logic [c_rec_w-1:0] mem_rdata
);

    localparam int                 c_idx_w      = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(N - 1);
    localparam logic [15:0]        c_force_base = 16'(FORCE_BASE);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    body_t              r_body;
    body_t              r_new;
    body_t              w_upd;
    logic signed [31:0] r_fx;
    logic signed [31:0] r_fy;
    force_rec_t         w_frec;
    logic               w_unused_pad;
    logic [15:0]        w_idx_addr;

    assign w_frec       = force_rec_t'(mem_rdata);
    assign w_unused_pad = ^w_frec.pad;
    assign w_idx_addr   = 16'(r_idx);

    body_update #(
        .DT_SHIFT  (DT_SHIFT),
        .POS_SHIFT (POS_SHIFT)
    ) u_body_update (
        .i_body (r_body),
        .i_fx   (r_fx),
        .i_fy   (r_fy),
        .o_body (w_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; read data is only sampled at the end of the CAP states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_body <= '0;
            r_fx   <= '0;
            r_fy   <= '0;
            r_new  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                    end
                end
                CAP_BODY: r_body <= body_t'(mem_rdata);
                CAP_FORCE: begin
                    r_fx <= w_frec.fx;
                    r_fy <= w_frec.fy;
                end
                UPDATE: r_new <= w_upd;
                NEXT: begin
                    if (r_idx != c_idx_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RD_BODY;
                end
            end
            RD_BODY: begin
                mem_rd_en   = 1'b1;
                mem_addr    = w_idx_addr;
                w_state_nxt = CAP_BODY;
            end
            CAP_BODY: w_state_nxt = RD_FORCE;
            RD_FORCE: begin
                mem_rd_en   = 1'b1;
                mem_addr    = c_force_base + w_idx_addr;
                w_state_nxt = CAP_FORCE;
            end
            CAP_FORCE: w_state_nxt = UPDATE;
            UPDATE:    w_state_nxt = WRITE;
            WRITE: begin
                mem_wr_en   = 1'b1;
                mem_addr    = w_idx_addr;
                mem_wdata   = r_new;
                w_state_nxt = NEXT;
            end
            NEXT: w_state_nxt = (r_idx == c_idx_last) ? DONE : RD_BODY;
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nbody_integrator.sv
`default_nettype none
// ============================================================================
// Module : tb_nbody_integrator
// Brief  : Self-checking bench: N=1 vector table plus N=16 sweeps, with a
//          BRAM model and an access scoreboard per instance.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_nbody_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start16;
    logic        done1, done16, rd1, rd16, wr1, wr16;
    logic [15:0] addr1, addr16;
    logic [79:0] wdata1, wdata16, rdata1, rdata16;
    logic [79:0] mem1  [0:511];
    logic [79:0] mem16 [0:511];
    int          cyc = 0;
    int          t1 = 0;
    int          t16 = 0;
    int          n_total = 0;
    int          n_bad = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [79:0] data;
        logic [31:0] rel;
    } ev_t;

    typedef struct {
        string              name;
        logic [79:0]        body;
        logic signed [31:0] fx;
        logic signed [31:0] fy;
        logic [79:0]        exp;
    } vec_t;

    ev_t  q1[$];
    ev_t  q16[$];
    vec_t vecs [5];
    logic [79:0]        sb_body [16];
    logic signed [31:0] sb_fx   [16];
    logic signed [31:0] sb_fy   [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nbody_integrator #(.N(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .done(done1),
        .mem_addr(addr1), .mem_rd_en(rd1), .mem_wr_en(wr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1)
    );

    nbody_integrator #(.N(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .done(done16),
        .mem_addr(addr16), .mem_rd_en(rd16), .mem_wr_en(wr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16)
    );

    always @(posedge clk) begin
        if (rd1)  rdata1  <= mem1[addr1[8:0]];
        if (wr1)  mem1[addr1[8:0]] <= wdata1;
        if (rd16) rdata16 <= mem16[addr16[8:0]];
        if (wr16) mem16[addr16[8:0]] <= wdata16;
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic wr, input int addr, input logic [79:0] data, input int rel);
        ev_t e;
        e.wr   = wr;
        e.addr = 16'(addr);
        e.data = data;
        e.rel  = 32'(rel);
        return e;
    endfunction

    task automatic observe(input string tag, input bit big, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [79:0] wd, input int rel);
        ev_t e;
        if (rd !== 1'b1 && wr !== 1'b1) return;
        check({tag, "_rd_wr_exclusive"}, 80'(rd & wr), 80'd0);
        if ((big && q16.size() == 0) || (!big && q1.size() == 0)) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_unexpected_access: got rd=%0b wr=%0b addr=%0d rel=%0d want none", tag, rd, wr, addr, rel);
            return;
        end
        if (big) e = q16.pop_front();
        else     e = q1.pop_front();
        check({tag, "_access_kind"},  80'(wr),   80'(e.wr));
        check({tag, "_access_addr"},  80'(addr), 80'(e.addr));
        check({tag, "_access_cycle"}, 80'(rel),  80'(e.rel));
        if (e.wr) check({tag, "_write_data"}, wd, e.data);
    endtask

    always @(negedge clk) observe("n1",  1'b0, rd1,  wr1,  addr1,  wdata1,  cyc - t1);
    always @(negedge clk) observe("n16", 1'b1, rd16, wr16, addr16, wdata16, cyc - t16);

    // Reference Euler step written directly from the arithmetic definition.
    function automatic logic [15:0] fit(input longint v);
`ifdef NBODY_INTEG_SATURATE_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic [31:0] axis(input logic signed [15:0] p, input logic signed [15:0] v,
                                         input logic signed [31:0] f);
        logic signed [15:0] vn;
        logic signed [15:0] pn;
        vn = fit(longint'(v) + longint'(f >>> 7));
        pn = fit(longint'(p) + longint'(vn >>> 2));
        return {pn, vn};
    endfunction

    function automatic logic [79:0] model_step(input logic [79:0] b, input logic signed [31:0] fx,
                                               input logic signed [31:0] fy);
        logic [31:0] ax;
        logic [31:0] ay;
        ax = axis(b[79:64], b[47:32], fx);
        ay = axis(b[63:48], b[31:16], fy);
        return {ax[31:16], ay[31:16], ax[15:0], ay[15:0], b[15:0]};
    endfunction

    task automatic push16(input int k);
        logic [79:0] nb;
        nb = model_step(sb_body[k], sb_fx[k], sb_fy[k]);
        q16.push_back(mk_ev(1'b0, k,       80'd0, 1 + 7 * k));
        q16.push_back(mk_ev(1'b0, 400 + k, 80'd0, 3 + 7 * k));
        q16.push_back(mk_ev(1'b1, k,       nb,    6 + 7 * k));
        sb_body[k] = nb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int rel;

        vecs[0].name = "basic";
        vecs[0].body = {16'd100, -16'sd50, 16'd10, 16'd0, 16'd5};
        vecs[0].fx   = 32'sd1280;
        vecs[0].fy   = -32'sd256;
        vecs[0].exp  = {16'd105, -16'sd51, 16'd20, -16'sd2, 16'd5};
        vecs[1].name = "vx_overflow";
        vecs[1].body = {16'd0, 16'd0, 16'd32000, 16'd0, 16'd7};
        vecs[1].fx   = 32'sh0010_0000;
        vecs[1].fy   = 32'sd0;
        vecs[2].name = "vy_underflow";
        vecs[2].body = {16'd0, 16'd0, 16'd0, -16'sd32000, 16'd9};
        vecs[2].fx   = 32'sd0;
        vecs[2].fy   = -32'sd1048576;
        vecs[3].name = "x_overflow";
        vecs[3].body = {16'd32760, 16'd0, 16'd100, 16'd0, 16'hffff};
        vecs[3].fx   = 32'sd0;
        vecs[3].fy   = 32'sd0;
`ifdef NBODY_INTEG_SATURATE_EN
        vecs[1].exp  = {16'd8191, 16'd0, 16'd32767, 16'd0, 16'd7};
        vecs[2].exp  = {16'd0, -16'sd8192, 16'd0, 16'h8000, 16'd9};
        vecs[3].exp  = {16'd32767, 16'd0, 16'd100, 16'd0, 16'hffff};
`else
        vecs[1].exp  = {-16'sd6336, 16'd0, -16'sd25344, 16'd0, 16'd7};
        vecs[2].exp  = {16'd0, 16'd6336, 16'd0, 16'd25344, 16'd9};
        vecs[3].exp  = {-16'sd32751, 16'd0, 16'd100, 16'd0, 16'hffff};
`endif
        vecs[4].name = "small_negative";
        vecs[4].body = {-16'sd1, 16'd7, -16'sd1, 16'd3, 16'd1234};
        vecs[4].fx   = -32'sd1;
        vecs[4].fy   = 32'sd127;
        vecs[4].exp  = {-16'sd2, 16'd7, -16'sd2, 16'd3, 16'd1234};

        reset = 1'b1;
        start1 = 1'b0;
        start16 = 1'b0;
        @(negedge clk); #1;
        check("reset_done16",  80'(done16), 80'd0);
        check("reset_rd16",    80'(rd16),   80'd0);
        check("reset_wr16",    80'(wr16),   80'd0);
        check("reset_addr16",  80'(addr16), 80'd0);
        check("reset_wdata16", wdata16,     80'd0);
        check("reset_done1",   80'(done1),  80'd0);
        check("reset_addr1",   80'(addr1),  80'd0);
        @(negedge clk); #1;
        reset = 1'b0;

        // N=1 vector table
        for (int r = 0; r < 5; r++) begin
            mem1[0]   <= vecs[r].body;
            mem1[400] <= {16'd0, vecs[r].fx, vecs[r].fy};
            q1.push_back(mk_ev(1'b0, 0,   80'd0,        1));
            q1.push_back(mk_ev(1'b0, 400, 80'd0,        3));
            q1.push_back(mk_ev(1'b1, 0,   vecs[r].exp,  6));
            t1 = cyc;
            start1 = 1'b1;
            first_done = -1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk); #1;
                if (done1 === 1'b1) begin
                    first_done = cyc - t1;
                    break;
                end
            end
            check({vecs[r].name, "_done_cycle"}, 80'(first_done), 80'd8);
            check({vecs[r].name, "_mem_body"},   mem1[0],         vecs[r].exp);
            check({vecs[r].name, "_queue_left"}, 80'(q1.size()),  80'd0);
            start1 = 1'b0;
            @(negedge clk); #1;
            check({vecs[r].name, "_idle_after"}, 80'(done1), 80'd0);
        end

        // N=16 load
        for (int k = 0; k < 16; k++) begin
            sb_body[k] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            sb_fx[k]   = $signed($urandom) >>> $urandom_range(4, 14);
            sb_fy[k]   = $signed($urandom) >>> $urandom_range(4, 14);
            mem16[k]       <= sb_body[k];
            mem16[400 + k] <= {16'd0, sb_fx[k], sb_fy[k]};
        end

        // Partial pass, reset during the write of body 3
        for (int k = 0; k < 4; k++) push16(k);
        t16 = cyc;
        start16 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (q16.size() == 0) break;
        end
        check("midpass_queue_left", 80'(q16.size()), 80'd0);
        check("midpass_in_write",   80'(wr16),       80'd1);
        reset = 1'b1;
        start16 = 1'b0;
        @(negedge clk); #1;
        check("midreset_done", 80'(done16), 80'd0);
        check("midreset_rd",   80'(rd16),   80'd0);
        check("midreset_wr",   80'(wr16),   80'd0);
        check("midreset_addr", 80'(addr16), 80'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        check("midreset_body3_kept", mem16[3], sb_body[3]);

        // Full pass with start toggled while busy
        for (int k = 0; k < 16; k++) push16(k);
        t16 = cyc;
        start16 = 1'b1;
        first_done = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            rel = cyc - t16;
            if (done16 === 1'b1 && first_done < 0) first_done = rel;
            if (rel == 10 || rel == 50 || rel == 90) start16 = 1'b0;
            if (rel == 25 || rel == 51 || rel == 100) start16 = 1'b1;
            if (rel >= 116) break;
        end
        check("sweep_done_cycle", 80'(first_done), 80'd113);
        check("sweep_done_held",  80'(done16),     80'd1);
        start16 = 1'b0;
        @(negedge clk); #1;
        check("sweep_idle_after_start_low", 80'(done16), 80'd0);
        @(negedge clk); #1;
        check("sweep_no_restart", 80'(rd16), 80'd0);
        check("sweep_queue_left", 80'(q16.size()), 80'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("sweep_mem_body%0d", k), mem16[k], sb_body[k]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nbody_integrator.md
# nbody_integrator

Position/velocity integrator. It is the reader side of the force write-back region of the body BRAM. After a force pass, the force engine has left one force record per body at `FORCE_BASE + i`. This block walks i = 0..N-1, reads body record i and force record i, applies a fixed-point Euler step, and writes the updated body back to address i. It shares the single BRAM port with the force engine; top-level control runs them in alternation.

## Interface
Parameters:
- `N`, 16, number of bodies.
- `FORCE_BASE`, 400, BRAM address of force record 0.
- `DT_SHIFT`, 7, timestep as right shift applied to force (dv = f >>> DT_SHIFT).
- `POS_SHIFT`, 2, right shift applied to the new velocity (dx = v_new >>> POS_SHIFT).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level request to run one integration pass.
- `done` out 1: pass complete; held high while in DONE.
- `mem_addr` out 16: BRAM address.
- `mem_rd_en` out 1: read strobe; data is returned one cycle later.
- `mem_wr_en` out 1: write strobe.
- `mem_wdata` out 80: body record {x, y, vx, vy, mass}, each 16 bits, in that order MSB-first.
- `mem_rdata` in 80: read data. A body record uses the layout above. A force record is {16'd0, fx[31:0], fy[31:0]}.

## Operation
- FSM states: IDLE, RD_BODY, CAP_BODY, RD_FORCE, CAP_FORCE, UPDATE, WRITE, NEXT, DONE.
- IDLE → RD_BODY when `start`=1. Index i is cleared on this transition.
- RD_BODY: `mem_rd_en`=1, `mem_addr`=i.
- CAP_BODY: register `mem_rdata` as the body.
- RD_FORCE: `mem_rd_en`=1, `mem_addr`=FORCE_BASE+i.
- CAP_FORCE: register fx and fy.
- UPDATE: register the result of the arithmetic below.
- WRITE: `mem_wr_en`=1, `mem_addr`=i, `mem_wdata`=updated record.
- NEXT: if i==N-1 go to DONE; otherwise i+1 and go to RD_BODY.
- DONE: `done`=1. Go to IDLE when `start`=0; stay in DONE while `start`=1.
- Arithmetic, all signed:
  - vx_ext = sext34(vx) + sext34(fx >>> DT_SHIFT).
  - vx_new = fit16(vx_ext).
  - x_ext = sext18(x) + sext18(vx_new >>> POS_SHIFT).
  - x_new = fit16(x_ext).
  - y and vy use the same formulas. mass is passed through unchanged.
- fit16 is either saturation or truncation; see Configuration.
- `start` is ignored outside IDLE. `mem_rdata` is ignored outside the CAP states.
- Outputs default to 0 in every state that does not drive them. `mem_rd_en` and `mem_wr_en` are never high in the same cycle.

## Timing
- Reset values: state IDLE, i=0, `done`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, all internal registers 0.
- Cycle 0 is the edge at which `start` is sampled in IDLE. Body k then occupies cycles 1+7k .. 7+7k:
  - read body at 1+7k;
  - read force at 3+7k;
  - write at 6+7k.
- DONE is entered at cycle 1+7N. With N=16, `done` first goes high at cycle 113.
- Read latency is exactly 1 cycle: data for the read issued in RD_x is sampled at the end of CAP_x.
- Reset mid-pass: the FSM is back in IDLE and all outputs are 0 on the cycle after `reset`. Bodies already written stay updated. The next `start` restarts from i=0.
- N=1 is legal: exactly one write, then DONE.

## Configuration
- Macro `NBODY_INTEG_SATURATE_EN`.
- Defined: fit16 clamps to [-32768, 32767].
- Undefined: fit16 takes the low 16 bits (two's-complement wrap), which gives a smaller datapath.

## Structure
- Shared package `nbody_pkg` holds:
  - `body_t` (x, y, vx, vy signed 16; mass unsigned 16);
  - `force_rec_t` ({pad16, fx32, fy32});
  - the default `FORCE_BASE` constant;
  - the record width constant (80).
- Sub-module `body_update`: a combinational Euler step for one body (body_t + fx/fy → body_t), containing fit16 and the macro-dependent clamp. The FSM registers its output in UPDATE.

## Test plan
- Reset check: assert `reset` for 2 cycles, including during WRITE → `done`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0 on the next cycle.
- Single-body step, N=1:
  - Stimulus: body {x=100, y=-50, vx=10, vy=0, mass=5}, force fx=1280, fy=-256.
  - Response: write {105, -51, 20, -2, 5} to address 0 at cycle 6, read of address 400 at cycle 3.
- Overflow:
  - Stimulus: vx=32000, fx=0x00100000.
  - Response with macro: vx=32767. Without macro: vx=-25344.
- Full sweep, N=16:
  - Reads alternate addresses k and 400+k; writes go to addresses 0..15 in order, once each.
  - `done` goes high at cycle 113 and stays high while `start`=1, then the FSM returns to IDLE one cycle after `start`=0.
- Mid-pass reset: pulse `reset` after body 3's write, then `start` again → bodies 0..3 are reprocessed starting from address 0; no write to address 4 before that restart.
- Start while busy: toggle `start` during the pass → no restart; write sequence and cycle count are unchanged.
